// File: rtl/touch_scan_ctrl.sv
// Fabric sequencer for a 4-wire resistive touchscreen: drives the plates, averages ADC
// samples per axis, validates and debounces the press, and reports X/Y coordinates.
module touch_scan_ctrl #(
  parameter int ADC_W      = 12,
  parameter int AVG_LOG2   = 2,
  parameter int SETTLE_CYC = 1000,
  parameter int GAP_CYC    = 50000,
  parameter int TIMEOUT    = 4096,
  parameter int MIN_VALID  = 64,
  parameter int MAX_VALID  = 4000,
  parameter int DEBOUNCE   = 3
) (
  input  logic             FAB_CLK,
  input  logic             FAB_RESET,
  input  logic             ENABLE,
  output logic             ADC_REQ,
  output logic             ADC_CH,
  input  logic             ADC_ACK,
  input  logic [ADC_W-1:0] ADC_DATA,
  output logic [3:0]       PIN_OUT,
  output logic [3:0]       PIN_OE,
  output logic [ADC_W-1:0] POS_X,
  output logic [ADC_W-1:0] POS_Y,
  output logic             POS_VALID,
  output logic             TOUCHED,
  output logic             ADC_ERR
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int SC_W  = AVG_LOG2 + 1;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [SC_W-1:0]  SC_LAST     = SC_W'((1 << AVG_LOG2) - 1);
  localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0]      GAP_LAST    = 32'(GAP_CYC - 1);
  localparam logic [31:0]      TMO_LAST    = 32'(TIMEOUT - 1);
  localparam logic [DB_W-1:0]  DB_MAX      = DB_W'(DEBOUNCE);
  localparam logic [ADC_W-1:0] MIN_V       = ADC_W'(MIN_VALID);
  localparam logic [ADC_W-1:0] MAX_V       = ADC_W'(MAX_VALID);

  typedef enum logic [2:0] {
    S_IDLE, S_X_SETTLE, S_X_CONV, S_XY_BREAK, S_Y_SETTLE, S_Y_CONV, S_REPORT, S_GAP
  } state_t;

  state_t            state, state_nx;
  logic [31:0]       cnt, tcnt;
  logic [SC_W-1:0]   scnt;
  logic [ACC_W-1:0]  acc, sum;
  logic [ADC_W-1:0]  avg_x, avg_y;
  logic [DB_W-1:0]   good_cnt, bad_cnt, good_inc, bad_inc;
  logic              ack_ok, last, tmo, in_conv, frame_good;

  assign ack_ok     = ADC_ACK && ADC_REQ;
  assign last       = ack_ok && (scnt == SC_LAST);
  assign tmo        = ADC_REQ && !ADC_ACK && (tcnt == TMO_LAST);
  assign in_conv    = (state == S_X_CONV) || (state == S_Y_CONV);
  assign sum        = acc + ACC_W'(ADC_DATA);
  assign frame_good = (avg_x >= MIN_V) && (avg_x <= MAX_V) && (avg_y >= MIN_V) && (avg_y <= MAX_V);
  assign good_inc   = (good_cnt == DB_MAX) ? good_cnt : good_cnt + DB_W'(1);
  assign bad_inc    = (bad_cnt == DB_MAX) ? bad_cnt : bad_cnt + DB_W'(1);

  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) state <= S_IDLE;
    else           state <= state_nx;
  end

  // Plate drive is decoded straight from the state register so reset floats the pins at once.
  always_comb begin
    state_nx = state;
    PIN_OE   = '0;
    PIN_OUT  = '0;
    ADC_CH   = 1'b0;
    case (state)
      S_IDLE: if (ENABLE) state_nx = S_X_SETTLE;
      S_X_SETTLE, S_X_CONV: begin
        PIN_OE  = 4'b0011;
        PIN_OUT = 4'b0001;
        ADC_CH  = 1'b1;
        if (state == S_X_SETTLE) begin
          if (!ENABLE)                  state_nx = S_IDLE;
          else if (cnt == SETTLE_LAST)  state_nx = S_X_CONV;
        end else begin
          if (tmo)                                 state_nx = ENABLE ? S_GAP : S_IDLE;
          else if (!ENABLE && (!ADC_REQ || ack_ok)) state_nx = S_IDLE;
          else if (last)                           state_nx = S_XY_BREAK;
        end
      end
      // One released cycle between the X and Y drive patterns.
      S_XY_BREAK: state_nx = ENABLE ? S_Y_SETTLE : S_IDLE;
      S_Y_SETTLE, S_Y_CONV: begin
        PIN_OE  = 4'b1100;
        PIN_OUT = 4'b0100;
        if (state == S_Y_SETTLE) begin
          if (!ENABLE)                  state_nx = S_IDLE;
          else if (cnt == SETTLE_LAST)  state_nx = S_Y_CONV;
        end else begin
          if (tmo)                                 state_nx = ENABLE ? S_GAP : S_IDLE;
          else if (!ENABLE && (!ADC_REQ || ack_ok)) state_nx = S_IDLE;
          else if (last)                           state_nx = S_REPORT;
        end
      end
      S_REPORT: state_nx = ENABLE ? S_GAP : S_IDLE;
      S_GAP: begin
        if (!ENABLE)              state_nx = S_IDLE;
        else if (cnt == GAP_LAST) state_nx = S_X_SETTLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      cnt       <= '0;
      tcnt      <= '0;
      scnt      <= '0;
      acc       <= '0;
      avg_x     <= '0;
      avg_y     <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      ADC_REQ   <= 1'b0;
      POS_X     <= '0;
      POS_Y     <= '0;
      POS_VALID <= 1'b0;
      TOUCHED   <= 1'b0;
      ADC_ERR   <= 1'b0;
    end else begin
      cnt       <= (state_nx != state) ? '0 : cnt + 32'd1;
      tcnt      <= (ADC_REQ && !ADC_ACK) ? tcnt + 32'd1 : '0;
      // Request is re-raised the cycle after a non-final ack and on entry to either CONV state.
      ADC_REQ   <= ((state_nx == S_X_CONV) || (state_nx == S_Y_CONV)) && !ack_ok && !tmo;
      ADC_ERR   <= tmo;
      POS_VALID <= 1'b0;

      if (!in_conv) begin
        acc  <= '0;
        scnt <= '0;
      end else if (ack_ok) begin
        if (last) begin
          acc  <= '0;
          scnt <= '0;
          if (state == S_X_CONV) avg_x <= ADC_W'(sum >> AVG_LOG2);
          else                   avg_y <= ADC_W'(sum >> AVG_LOG2);
        end else begin
          acc  <= sum;
          scnt <= scnt + SC_W'(1);
        end
      end

      if (state == S_REPORT) begin
        if (frame_good) begin
          POS_X     <= avg_x;
          POS_Y     <= avg_y;
          POS_VALID <= 1'b1;
          bad_cnt   <= '0;
          good_cnt  <= good_inc;
          if (good_inc == DB_MAX) TOUCHED <= 1'b1;
        end else begin
          good_cnt <= '0;
          bad_cnt  <= bad_inc;
          if (bad_inc == DB_MAX) TOUCHED <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Scoreboard bench for touch_scan_ctrl: directed ADC sample sets with hand-computed averages,
// debounce, timeout, enable-drop and mid-frame reset scenarios.
module tb_touch_scan_ctrl;
  localparam int ADC_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             adc_ack = 1'b0;
  logic [ADC_W-1:0] adc_data = '0;
  logic             adc_req, adc_ch, pos_valid, touched, adc_err;
  logic [3:0]       pin_out, pin_oe;
  logic [ADC_W-1:0] pos_x, pos_y;

  touch_scan_ctrl #(
    .ADC_W(ADC_W), .AVG_LOG2(2), .SETTLE_CYC(20), .GAP_CYC(40), .TIMEOUT(4096),
    .MIN_VALID(64), .MAX_VALID(4000), .DEBOUNCE(3)
  ) dut (
    .FAB_CLK(clk), .FAB_RESET(rst), .ENABLE(en),
    .ADC_REQ(adc_req), .ADC_CH(adc_ch), .ADC_ACK(adc_ack), .ADC_DATA(adc_data),
    .PIN_OUT(pin_out), .PIN_OE(pin_oe),
    .POS_X(pos_x), .POS_Y(pos_y), .POS_VALID(pos_valid),
    .TOUCHED(touched), .ADC_ERR(adc_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADC_W-1:0] x; logic [ADC_W-1:0] y; } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  bit ack_en = 1'b1;
  logic [ADC_W-1:0] xs [4];
  logic [ADC_W-1:0] ys [4];
  int xi = 0;
  int yi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ADC model: ack 5 cycles after a request is seen, data chosen by the sense channel.
  initial begin
    logic ch0;
    forever begin
      @(negedge clk);
      if (adc_req === 1'b1 && ack_en) begin
        ch0 = adc_ch;
        repeat (5) @(negedge clk);
        if (adc_req) check("adc_ch_stable", {31'd0, adc_ch}, {31'd0, ch0});
        adc_ack = 1'b1;
        if (adc_ch) begin adc_data = xs[xi]; xi = (xi + 1) % 4; end
        else        begin adc_data = ys[yi]; yi = (yi + 1) % 4; end
        @(negedge clk);
        adc_ack = 1'b0;
      end
    end
  end

  // Scoreboard monitor for coordinate reports.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pos_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_pos_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pos_x", 32'(pos_x), 32'(e.x));
          check("pos_y", 32'(pos_y), 32'(e.y));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (adc_err) err_cnt++;
    end
  end

  // Plate drive must always pass through high-Z between X and Y patterns.
  initial begin
    logic [3:0] prev;
    logic [3:0] exp_out;
    prev = 4'b0000;
    forever begin
      @(negedge clk);
      if (pin_oe != prev) begin
        check("oe_break_before_make",
              32'(((prev == 4'b0000) && (pin_oe == 4'b0011 || pin_oe == 4'b1100)) ||
                  ((prev == 4'b0011 || prev == 4'b1100) && pin_oe == 4'b0000)), 32'd1);
        exp_out = (pin_oe == 4'b0011) ? 4'b0001 : (pin_oe == 4'b1100) ? 4'b0100 : 4'b0000;
        check("pin_out_pattern", 32'(pin_out), 32'(exp_out));
        prev = pin_oe;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Returns one cycle after the Y plate is released at frame end (POS_VALID/TOUCHED visible).
  task automatic wait_frame(input string tag);
    logic [3:0] p;
    int n;
    bit done;
    p = pin_oe;
    n = 0;
    done = 1'b0;
    do begin
      @(negedge clk);
      n++;
      done = (p == 4'b1100) && (pin_oe == 4'b0000);
      p = pin_oe;
    end while (!done && n < 20000);
    check({tag, "_frame_end"}, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_cond_req(input string tag);
    int n;
    n = 0;
    while (adc_req !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check({tag, "_req_seen"}, {31'd0, adc_req}, 32'd1);
  endtask

  task automatic wait_oe(input string tag, input logic [3:0] want, input int budget);
    int n;
    n = 0;
    while (pin_oe !== want && n < budget) begin @(negedge clk); n++; end
    check({tag, "_oe"}, 32'(pin_oe), 32'(want));
  endtask

  initial begin
    int n;
    xs = '{12'd1000, 12'd1001, 12'd1002, 12'd1003};
    ys = '{12'd2000, 12'd2000, 12'd2000, 12'd2000};

    // 1: reset, then idle with ENABLE low
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("t1_pin_oe", 32'(pin_oe), 32'd0);
    check("t1_pin_out", 32'(pin_out), 32'd0);
    check("t1_adc_req", {31'd0, adc_req}, 32'd0);
    check("t1_adc_ch", {31'd0, adc_ch}, 32'd0);
    check("t1_pos_x", 32'(pos_x), 32'd0);
    check("t1_pos_y", 32'(pos_y), 32'd0);
    check("t1_touched", {31'd0, touched}, 32'd0);
    check("t1_adc_err", {31'd0, adc_err}, 32'd0);

    // 2: three good frames, touch asserts on the third
    repeat (3) sb.push_back('{x: 12'd1001, y: 12'd2000});
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_frame("t2");
      check("t2_touched", {31'd0, touched}, (i == 2) ? 32'd1 : 32'd0);
    end

    // 3: release (Y below MIN_VALID): positions hold, touch falls after third bad frame
    ys = '{12'd10, 12'd10, 12'd10, 12'd10};
    for (int i = 0; i < 3; i++) begin
      wait_frame("t3");
      check("t3_touched", {31'd0, touched}, (i == 2) ? 32'd0 : 32'd1);
      check("t3_pos_x_hold", 32'(pos_x), 32'd1001);
      check("t3_pos_y_hold", 32'(pos_y), 32'd2000);
    end

    // 4: two good frames, an ADC timeout, then one good frame completes the debounce
    ys = '{12'd2000, 12'd2000, 12'd2000, 12'd2000};
    repeat (2) sb.push_back('{x: 12'd1001, y: 12'd2000});
    for (int i = 0; i < 2; i++) begin
      wait_frame("t4");
      check("t4_touched_pre", {31'd0, touched}, 32'd0);
    end
    ack_en = 1'b0;
    wait_cond_req("t4");
    n = 0;
    while (adc_req && n < 5000) begin @(negedge clk); n++; end
    check("t4_req_high_cycles", 32'(n), 32'd4096);
    check("t4_adc_err", {31'd0, adc_err}, 32'd1);
    check("t4_gap_oe", 32'(pin_oe), 32'd0);
    ack_en = 1'b1;
    wait_oe("t4_next_frame", 4'b0011, 60);
    check("t4_err_count", 32'(err_cnt), 32'd1);
    sb.push_back('{x: 12'd1001, y: 12'd2000});
    wait_frame("t4b");
    check("t4_touched_post", {31'd0, touched}, 32'd1);

    // 5: ENABLE drops with a request outstanding
    xs = '{12'd1500, 12'd1500, 12'd1500, 12'd1500};
    wait_cond_req("t5");
    en = 1'b0;
    n = 0;
    while (adc_req && n < 50) begin @(negedge clk); n++; end
    check("t5_req_held_cycles", 32'(n), 32'd6);
    check("t5_idle_oe", 32'(pin_oe), 32'd0);
    repeat (20) @(negedge clk);
    check("t5_idle_oe_later", 32'(pin_oe), 32'd0);
    check("t5_idle_req", {31'd0, adc_req}, 32'd0);
    check("t5_touched_hold", {31'd0, touched}, 32'd1);
    en = 1'b1;
    @(negedge clk);
    check("t5_restart_x_settle", 32'(pin_oe), 32'd3);
    sb.push_back('{x: 12'd1500, y: 12'd2000});
    wait_frame("t5");
    check("t5_touched", {31'd0, touched}, 32'd1);

    // 6: reset during Y conversion
    n = 0;
    while (!(pin_oe == 4'b1100 && adc_req) && n < 2000) begin @(negedge clk); n++; end
    check("t6_in_y_conv", 32'(pin_oe == 4'b1100 && adc_req), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_oe", 32'(pin_oe), 32'd0);
    check("t6_rst_out", 32'(pin_out), 32'd0);
    check("t6_rst_req", {31'd0, adc_req}, 32'd0);
    check("t6_rst_pos_x", 32'(pos_x), 32'd0);
    check("t6_rst_touched", {31'd0, touched}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_oe("t6_restart", 4'b0011, 5);
    sb.push_back('{x: 12'd1500, y: 12'd2000});
    wait_frame("t6");
    check("t6_touched_one_frame", {31'd0, touched}, 32'd0);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("err_count_final", 32'(err_cnt), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
